// File: rtl/tdc_ctrl_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
package tdc_ctrl_pkg;

  localparam int CNT_W     = 16;
  localparam int MAX_HITS  = 4;
  localparam int HIT_W     = $clog2(MAX_HITS);
  localparam int ARM_GUARD = 8;
  localparam int GUARD_W   = $clog2(ARM_GUARD);

  typedef enum logic [2:0] {IDLE, ARM, RUN, CLEAR, DRAIN} state_t;

  typedef struct packed {
    logic             tmo;
    logic             last;
    logic [HIT_W-1:0] idx;
    logic [CNT_W-1:0] data;
  } hit_t;

  // 0 means one hit; anything above the FIFO depth is cut to the depth
  function automatic logic [HIT_W:0] clamp_hits(input logic [HIT_W:0] h);
    if (h == '0) return (HIT_W+1)'(1);
    if (h > (HIT_W+1)'(MAX_HITS)) return (HIT_W+1)'(MAX_HITS);
    return h;
  endfunction

  // 0 selects the longest run the counter can express without wrapping
  function automatic logic [CNT_W-1:0] clamp_timeout(input logic [CNT_W-1:0] t);
    return (t == '0) ? '1 : t;
  endfunction

endpackage

// File: rtl/tdc_hit_fifo.sv
// Small synchronous FIFO for hit entries. Write pointer is derived from the
// read pointer plus occupancy, so DEPTH must be a power of two.
module tdc_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 20
) (
  input  logic         clk5,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] rdata
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;

  assign wr_ptr  = rd_ptr + count[AW-1:0];
  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = valid && ready;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // storage, pointer and occupancy; reset drops everything queued
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wdata;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms the start synchroniser, timestamps stop
// edges with the coarse counter, ends on hit count or timeout with an
// overflow pulse, and drains the results through a valid/ready stream.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
(
  input  logic             clk5,
  input  logic             rst_n,
  input  logic             meas_req,
  input  logic [HIT_W:0]   cfg_hits,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic             meas_busy,
  output logic             tdc_start,
  output logic             overflow,
  input  logic             cnt_en,
  input  logic             coarse_tri,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [CNT_W-1:0] hit_data,
  output logic [HIT_W-1:0] hit_idx,
  output logic             hit_last,
  output logic             hit_tmo,
  output logic             arm_err
);
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, tmo_cfg;
  logic [HIT_W:0]     hit_cnt, hits_cfg;
  logic [GUARD_W-1:0] guard;
  logic               guard_done, tmo_now, last_hit;
  logic               tmo_pend, set_pend, push, hit_push;
  hit_t               push_ent, pop_ent;
  logic [$bits(hit_t)-1:0] pop_raw;

  assign guard_done = (guard == GUARD_W'(ARM_GUARD-1));
  assign tmo_now    = (cnt == tmo_cfg);
  assign last_hit   = ((hit_cnt + 1'b1) == hits_cfg);

  assign meas_busy = (state != IDLE);
  assign tdc_start = (state == ARM) || (state == RUN);
  assign overflow  = (state == CLEAR);

  // state register
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and FIFO push; a non-final hit coinciding with the timeout
  // defers the marker by one cycle so both entries get their own push slot
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    hit_push  = 1'b0;
    set_pend  = 1'b0;
    push_ent  = '0;
    unique case (state)
      IDLE:  if (meas_req) state_nxt = ARM;
      ARM: begin
        if (cnt_en)          state_nxt = RUN;
        else if (guard_done) state_nxt = CLEAR;
      end
      RUN: begin
        if (tmo_pend) begin
          push      = 1'b1;
          push_ent  = '{tmo: 1'b1, last: 1'b1, idx: hit_cnt[HIT_W-1:0], data: tmo_cfg};
          state_nxt = CLEAR;
        end else if (coarse_tri) begin
          push      = 1'b1;
          hit_push  = 1'b1;
          push_ent  = '{tmo: 1'b0, last: last_hit, idx: hit_cnt[HIT_W-1:0], data: cnt};
          if (last_hit)     state_nxt = CLEAR;
          else if (tmo_now) set_pend  = 1'b1;
        end else if (tmo_now) begin
          push      = 1'b1;
          push_ent  = '{tmo: 1'b1, last: 1'b1, idx: hit_cnt[HIT_W-1:0], data: tmo_cfg};
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = DRAIN;
      DRAIN: if (!hit_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // config latch, coarse counter, hit count, arm guard and sticky arm error
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tmo_cfg  <= '0;
      hits_cfg <= '0;
      hit_cnt  <= '0;
      guard    <= '0;
      arm_err  <= 1'b0;
      tmo_pend <= 1'b0;
    end else begin
      tmo_pend <= set_pend;
      unique case (state)
        IDLE: if (meas_req) begin
          hits_cfg <= clamp_hits(cfg_hits);
          tmo_cfg  <= clamp_timeout(cfg_timeout);
          cnt      <= '0;
          hit_cnt  <= '0;
          guard    <= '0;
          arm_err  <= 1'b0;
        end
        ARM: begin
          if (cnt_en) cnt <= '0;
          else begin
            guard <= guard + 1'b1;
            if (guard_done) arm_err <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_en && !tmo_now) cnt <= cnt + 1'b1;
          if (hit_push) hit_cnt <= hit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  tdc_hit_fifo #(
    .DEPTH (MAX_HITS),
    .AW    (HIT_W),
    .W     ($bits(hit_t))
  ) u_fifo (
    .clk5  (clk5),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_ent),
    .valid (hit_valid),
    .ready (hit_ready),
    .rdata (pop_raw)
  );

  assign pop_ent  = hit_t'(pop_raw);
  assign hit_data = pop_ent.data;
  assign hit_idx  = pop_ent.idx;
  assign hit_last = pop_ent.last;
  assign hit_tmo  = pop_ent.tmo;

endmodule
